// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants.
// Provides default register-file address/data widths and the hard-wired zero register index.
package mips_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req     - N request lines
//   ptr     - highest-priority index for this cycle (0..N-1)
//   grant_c - one-hot grant (all zero when no request)
//   idx_c   - encoded index of the granted request
//   any_c   - at least one request is present
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the closest request to ptr is the last one kept.
    always_comb begin
        any_c   = 1'b0;
        idx_c   = '0;
        cand    = '0;
        grant_c = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % int'(N));
            if (req[cand]) begin
                any_c = 1'b1;
                idx_c = cand;
            end
        end
        if (any_c) begin
            grant_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Slot scheduler for a single-port register file (one write OR one dual read per cycle).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   wr_valid/addr/data       - NUM_WR packed write-back requests; wr_ready is the one-hot accept
//   rd_valid, rd_addr_1/2    - decode-stage dual read request; rd_ready is the accept
//   rd_data_valid            - pulse the cycle after a read accept; rd_data_1/2 are then valid
//   rf_*                     - direct drive of the register file control/address/data inputs
//   rf_data_out_1/2          - registered read data from the register file
module regfile_port_scheduler
    import mips_pkg::*;
#(
    parameter int unsigned NUM_WR     = 3,
    parameter int unsigned ADDR_W     = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_valid,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [NUM_WR-1:0]          wr_ready,
    input  logic                       rd_valid,
    input  logic [ADDR_W-1:0]          rd_addr_1,
    input  logic [ADDR_W-1:0]          rd_addr_2,
    output logic                       rd_ready,
    output logic                       rd_data_valid,
    output logic [DATA_W-1:0]          rd_data_1,
    output logic [DATA_W-1:0]          rd_data_2,
    output logic                       rf_RegWrite,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [ADDR_W-1:0]          rf_read_addr_1,
    output logic [ADDR_W-1:0]          rf_read_addr_2,
    input  logic [DATA_W-1:0]          rf_data_out_1,
    input  logic [DATA_W-1:0]          rf_data_out_2
);

    localparam int unsigned IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int unsigned CNT_W = 4;

    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;

    logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
    logic [DATA_W-1:0] wr_data_a [NUM_WR];

    logic [NUM_WR-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    logic              rd_forced;
    logic              wr_slot;
    logic              win_zero;

    // Unpack the flat requester buses.
    for (genvar i = 0; i < NUM_WR; i++) begin : g_unpack
        assign wr_addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
        assign wr_data_a[i] = wr_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N     (NUM_WR),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (wr_valid),
        .ptr     (rr_ptr),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .any_c   (arb_any)
    );

    // Read data is the register file's own output register; no extra staging.
    assign rd_data_1 = rf_data_out_1;
    assign rd_data_2 = rf_data_out_2;

    // Slot decision and next state; every port output held at zero while rst is high.
    always_comb begin
        wr_ready       = '0;
        rd_ready       = 1'b0;
        rf_RegWrite    = 1'b0;
        rf_write_addr  = '0;
        rf_write_data  = '0;
        rf_read_addr_1 = '0;
        rf_read_addr_2 = '0;
        rr_ptr_nxt     = rr_ptr;
        starve_cnt_nxt = starve_cnt;

        rd_forced = rd_valid && (starve_cnt >= CNT_W'(STARVE_MAX));
        wr_slot   = arb_any && !rd_forced;
        win_zero  = (wr_addr_a[arb_idx] == ADDR_W'(REG_ZERO));

        if (!rst) begin
            rf_read_addr_1 = rd_addr_1;
            rf_read_addr_2 = rd_addr_2;

            if (wr_slot) begin
                wr_ready      = arb_grant;
                rf_write_addr = wr_addr_a[arb_idx];
                rf_write_data = wr_data_a[arb_idx];
                rf_RegWrite   = !win_zero;
                rr_ptr_nxt    = (arb_idx == IDX_W'(NUM_WR - 1)) ? '0 : arb_idx + IDX_W'(1);
            end

            // A dropped r0 write leaves the port free, so a pending read rides along.
            rd_ready = rd_valid && (!wr_slot || win_zero);

            if (!rd_valid || rd_ready) begin
                starve_cnt_nxt = '0;
            end else if (starve_cnt != '1) begin
                starve_cnt_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            starve_cnt    <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rr_ptr        <= rr_ptr_nxt;
            starve_cnt    <= starve_cnt_nxt;
            rd_data_valid <= rd_ready;
        end
    end

endmodule
